// File: rtl/key_debounce_if.sv
// Key front-end bundle: raw active-low key pins in, debounced level and
// one-cycle event pulses out. Bit i of every field belongs to key i.
//
// Pulse semantics: key_press, key_release and key_long are single-cycle
// strobes with no backpressure. The consumer must sample them on every
// sys_clk edge. key_state is a level that stays valid until the next
// press or release pulse.
interface key_debounce_if;
    logic [3:0] key_in;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    // Board or bench side: drives the raw pins and consumes the events.
    modport master (
        output key_in,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long
    );

    // Debouncer side.
    modport slave (
        input  key_in,
        output key_state,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce.sv
// Four independent push-button channels. Each channel has a two-flop
// synchronizer, a stability counter that accepts a new level only after it
// has held for DEB_MAX cycles, and a saturating hold counter that fires
// key_long once per press. All outputs are registered.
module key_debounce #(
    parameter int DEB_MAX    = 1_000_000,
    parameter int DEB_WIDTH  = 20,
    parameter int LONG_MAX   = 50_000_000,
    parameter int LONG_WIDTH = 26
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    key_debounce_if.slave keys
);

    localparam int NUM_KEYS = 4;

    localparam logic [DEB_WIDTH-1:0]  DEB_LAST  = DEB_WIDTH'(DEB_MAX - 1);
    localparam logic [DEB_WIDTH-1:0]  DEB_ONE   = DEB_WIDTH'(1);
    localparam logic [LONG_WIDTH-1:0] LONG_LAST = LONG_WIDTH'(LONG_MAX - 1);
    localparam logic [LONG_WIDTH-1:0] LONG_TOP  = LONG_WIDTH'(LONG_MAX);
    localparam logic [LONG_WIDTH-1:0] LONG_ONE  = LONG_WIDTH'(1);

    logic [NUM_KEYS-1:0]   sync_q1;
    logic [NUM_KEYS-1:0]   sync_q2;
    logic [NUM_KEYS-1:0]   sync_pressed;

    logic [DEB_WIDTH-1:0]  deb_cnt  [NUM_KEYS];
    logic [LONG_WIDTH-1:0] hold_cnt [NUM_KEYS];

    logic [NUM_KEYS-1:0]   state_q;
    logic [NUM_KEYS-1:0]   press_q;
    logic [NUM_KEYS-1:0]   release_q;
    logic [NUM_KEYS-1:0]   long_q;

    // Pins are active-low, so the synchronized level is inverted to give 1 = pressed.
    assign sync_pressed = ~sync_q2;

    assign keys.key_state   = state_q;
    assign keys.key_press   = press_q;
    assign keys.key_release = release_q;
    assign keys.key_long    = long_q;

    // Two-flop synchronizer; resets to the released pin level so reset exit never looks like a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= keys.key_in;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce: a differing level must persist DEB_MAX cycles before it is accepted; any return clears the count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                press_q[i]   <= 1'b0;
                release_q[i] <= 1'b0;
                if (sync_pressed[i] == state_q[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    state_q[i]   <= sync_pressed[i];
                    press_q[i]   <= sync_pressed[i];
                    release_q[i] <= ~sync_pressed[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
                end
            end
        end
    end

    // Hold counter: counts while pressed, pulses once at LONG_MAX and then saturates until release.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            long_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                long_q[i] <= 1'b0;
                if (!state_q[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] == LONG_LAST) begin
                    hold_cnt[i] <= LONG_TOP;
                    long_q[i]   <= 1'b1;
                end else if (hold_cnt[i] == LONG_TOP) begin
                    hold_cnt[i] <= LONG_TOP;
                end else begin
                    hold_cnt[i] <= hold_cnt[i] + LONG_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEB_MAX=16, LONG_MAX=64.
// Inputs change 1 time unit after a rising edge. Outputs are checked at the
// same point, so the next rising edge is the first sampling edge of a new level.
module tb_key_debounce;

    localparam int DEB_MAX  = 16;
    localparam int LONG_MAX = 64;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    // Clock: 10 time-unit period.
    always #5 sys_clk = ~sys_clk;

    key_debounce_if kif ();

    key_debounce #(
        .DEB_MAX    (DEB_MAX),
        .DEB_WIDTH  (5),
        .LONG_MAX   (LONG_MAX),
        .LONG_WIDTH (7)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .keys      (kif.slave)
    );

    typedef struct {
        string      name;
        logic [3:0] key_in;
        int         cycles;
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lg;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    // Event counters, updated on the falling edge.
    int press_cnt [4] = '{default: 0};
    int rel_cnt   [4] = '{default: 0};
    int long_cnt  [4] = '{default: 0};
    int dbl_viol  = 0;
    logic [3:0] prev_p = '0;
    logic [3:0] prev_r = '0;
    logic [3:0] prev_l = '0;

    int snap_p [4];
    int snap_r [4];
    int snap_l [4];

    // Monitor: tally pulses per bit and flag any pulse high on two consecutive cycles.
    always @(negedge sys_clk) begin
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = press_cnt[i] + int'(kif.key_press[i]);
            rel_cnt[i]   = rel_cnt[i] + int'(kif.key_release[i]);
            long_cnt[i]  = long_cnt[i] + int'(kif.key_long[i]);
        end
        if ((prev_p & kif.key_press) != 4'h0)   dbl_viol = dbl_viol + 1;
        if ((prev_r & kif.key_release) != 4'h0) dbl_viol = dbl_viol + 1;
        if ((prev_l & kif.key_long) != 4'h0)    dbl_viol = dbl_viol + 1;
        prev_p = kif.key_press;
        prev_r = kif.key_release;
        prev_l = kif.key_long;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] st, input logic [3:0] pr,
                              input logic [3:0] rl, input logic [3:0] lg);
        check4($sformatf("%s.state", name),   kif.key_state,   st);
        check4($sformatf("%s.press", name),   kif.key_press,   pr);
        check4($sformatf("%s.release", name), kif.key_release, rl);
        check4($sformatf("%s.long", name),    kif.key_long,    lg);
    endtask

    task automatic add(input string name, input logic [3:0] k, input int c, input logic [3:0] st,
                       input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] lg);
        vec_t v;
        v.name = name; v.key_in = k; v.cycles = c;
        v.st = st; v.pr = pr; v.rl = rl; v.lg = lg;
        vecs.push_back(v);
    endtask

    // Hold key_in for v.cycles edges: quiet outputs in between, expected outputs after the last edge.
    task automatic run_vec(input vec_t v);
        kif.key_in = v.key_in;
        for (int c = 1; c < v.cycles; c++) begin
            tick();
            check_outs($sformatf("%s_mid%0d", v.name, c), v.st, 4'h0, 4'h0, 4'h0);
        end
        tick();
        check_outs(v.name, v.st, v.pr, v.rl, v.lg);
    endtask

    task automatic take_snap();
        snap_p = press_cnt;
        snap_r = rel_cnt;
        snap_l = long_cnt;
    endtask

    initial begin
        // Table: {key_in, edges, expected state/press/release/long after the last edge}.
        add("idle",        4'hF, 100, 4'h0, 4'h0, 4'h0, 4'h0);
        // Key 0: clean press and release, 18 edges each.
        add("k0_wait",     4'hE,  17, 4'h0, 4'h0, 4'h0, 4'h0);
        add("k0_press",    4'hE,   1, 4'h1, 4'h1, 4'h0, 4'h0);
        add("k0_after",    4'hE,   1, 4'h1, 4'h0, 4'h0, 4'h0);
        add("k0_rwait",    4'hF,  17, 4'h1, 4'h0, 4'h0, 4'h0);
        add("k0_release",  4'hF,   1, 4'h0, 4'h0, 4'h1, 4'h0);
        add("k0_rafter",   4'hF,   1, 4'h0, 4'h0, 4'h0, 4'h0);
        // Key 1: 60 cycles of 5-cycle bounce bursts, then stable.
        for (int b = 0; b < 6; b++) begin
            add($sformatf("k1_bounce_lo%0d", b), 4'hD, 5, 4'h0, 4'h0, 4'h0, 4'h0);
            add($sformatf("k1_bounce_hi%0d", b), 4'hF, 5, 4'h0, 4'h0, 4'h0, 4'h0);
        end
        add("k1_wait",     4'hD,  17, 4'h0, 4'h0, 4'h0, 4'h0);
        add("k1_press",    4'hD,   1, 4'h2, 4'h2, 4'h0, 4'h0);
        add("k1_after",    4'hD,   1, 4'h2, 4'h0, 4'h0, 4'h0);
        add("k1_rwait",    4'hF,  17, 4'h2, 4'h0, 4'h0, 4'h0);
        add("k1_release",  4'hF,   1, 4'h0, 4'h0, 4'h2, 4'h0);
        add("k1_rafter",   4'hF,   1, 4'h0, 4'h0, 4'h0, 4'h0);
        // Key 2: held 200 cycles, long press 64 edges after key_press, no repeat.
        add("k2_wait",     4'hB,  17, 4'h0, 4'h0, 4'h0, 4'h0);
        add("k2_press",    4'hB,   1, 4'h4, 4'h4, 4'h0, 4'h0);
        add("k2_lwait",    4'hB,  63, 4'h4, 4'h0, 4'h0, 4'h0);
        add("k2_long",     4'hB,   1, 4'h4, 4'h0, 4'h0, 4'h4);
        add("k2_lafter",   4'hB,   1, 4'h4, 4'h0, 4'h0, 4'h0);
        add("k2_sat",      4'hB, 117, 4'h4, 4'h0, 4'h0, 4'h0);
        add("k2_rwait",    4'hF,  17, 4'h4, 4'h0, 4'h0, 4'h0);
        add("k2_release",  4'hF,   1, 4'h0, 4'h0, 4'h4, 4'h0);
        add("k2_rafter",   4'hF,   1, 4'h0, 4'h0, 4'h0, 4'h0);
        // Key 3: held 40 cycles, short of a long press.
        add("k3_wait",     4'h7,  17, 4'h0, 4'h0, 4'h0, 4'h0);
        add("k3_press",    4'h7,   1, 4'h8, 4'h8, 4'h0, 4'h0);
        add("k3_hold",     4'h7,  22, 4'h8, 4'h0, 4'h0, 4'h0);
        add("k3_rwait",    4'hF,  17, 4'h8, 4'h0, 4'h0, 4'h0);
        add("k3_release",  4'hF,   1, 4'h0, 4'h0, 4'h8, 4'h0);
        add("k3_rafter",   4'hF,   1, 4'h0, 4'h0, 4'h0, 4'h0);

        // Reset with keys released.
        kif.key_in = 4'hF;
        sys_rst_n  = 1'b0;
        repeat (3) tick();
        check_outs("in_reset", 4'h0, 4'h0, 4'h0, 4'h0);
        sys_rst_n = 1'b1;

        for (int n = 0; n < vecs.size(); n++) begin
            run_vec(vecs[n]);
        end

        // One press and one release per key, one long press on key 2 only.
        for (int i = 0; i < 4; i++) begin
            check_int($sformatf("table_press_count%0d", i),   press_cnt[i], 1);
            check_int($sformatf("table_release_count%0d", i), rel_cnt[i],   1);
            check_int($sformatf("table_long_count%0d", i),    long_cnt[i],  (i == 2) ? 1 : 0);
        end

        // Keys 0 and 3 pressed together, then reset mid-hold with key 3 still down.
        take_snap();
        kif.key_in = 4'h6;
        for (int c = 0; c < 17; c++) begin
            tick();
            check_outs("dual_wait", 4'h0, 4'h0, 4'h0, 4'h0);
        end
        tick();
        check_outs("dual_press", 4'h9, 4'h9, 4'h0, 4'h0);
        tick();
        check_outs("dual_after", 4'h9, 4'h0, 4'h0, 4'h0);
        repeat (20) tick();
        check_outs("dual_hold", 4'h9, 4'h0, 4'h0, 4'h0);

        sys_rst_n  = 1'b0;
        kif.key_in = 4'h7;
        #1;
        check_outs("rst_async", 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (3) tick();
        check_outs("rst_held", 4'h0, 4'h0, 4'h0, 4'h0);
        sys_rst_n = 1'b1;

        for (int c = 0; c < 17; c++) begin
            tick();
            check_outs("post_rst_wait", 4'h0, 4'h0, 4'h0, 4'h0);
        end
        tick();
        check_outs("post_rst_press", 4'h8, 4'h8, 4'h0, 4'h0);
        for (int c = 0; c < 63; c++) begin
            tick();
            check_outs("post_rst_hold", 4'h8, 4'h0, 4'h0, 4'h0);
        end
        tick();
        check_outs("post_rst_long", 4'h8, 4'h0, 4'h0, 4'h8);
        tick();
        check_outs("post_rst_lafter", 4'h8, 4'h0, 4'h0, 4'h0);

        kif.key_in = 4'hF;
        for (int c = 0; c < 17; c++) begin
            tick();
            check_outs("post_rst_rwait", 4'h8, 4'h0, 4'h0, 4'h0);
        end
        tick();
        check_outs("post_rst_release", 4'h0, 4'h0, 4'h8, 4'h0);
        repeat (5) tick();
        check_outs("final_idle", 4'h0, 4'h0, 4'h0, 4'h0);

        check_int("dual_press_count0",   press_cnt[0] - snap_p[0], 1);
        check_int("dual_press_count3",   press_cnt[3] - snap_p[3], 2);
        check_int("dual_release_count0", rel_cnt[0] - snap_r[0],   0);
        check_int("dual_release_count3", rel_cnt[3] - snap_r[3],   1);
        check_int("dual_long_count0",    long_cnt[0] - snap_l[0],  0);
        check_int("dual_long_count3",    long_cnt[3] - snap_l[3],  1);
        check_int("no_double_pulse",     dbl_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Four-channel push-button front end for the board's active-low keys. Synchronizes each raw key input, removes contact bounce with a per-key stability counter, and produces a clean level plus one-cycle press, release and long-press pulses. Sits between the board key pins and the LED control logic, which consumes the pulses to step or alter the LED pattern.

## Interface
- DEB_MAX, 1_000_000: cycles a new level must persist before it is accepted (20 ms at 50 MHz)
- DEB_WIDTH, 20: width of each debounce counter; must hold DEB_MAX-1
- LONG_MAX, 50_000_000: cycles a debounced press must persist to fire key_long (1 s at 50 MHz)
- LONG_WIDTH, 26: width of each hold counter; must hold LONG_MAX
- sys_clk  input  1  system clock, 50 MHz
- sys_rst_n  input  1  reset, asynchronous, active-low
- key_in  input  4  raw key pins, 0 = pressed, asynchronous to sys_clk
- key_state  output  4  debounced level, 1 = pressed
- key_press  output  4  one-cycle pulse when key_state rises
- key_release  output  4  one-cycle pulse when key_state falls
- key_long  output  4  one-cycle pulse when a press has lasted LONG_MAX cycles

## Operation
- Four identical, fully independent channels; bit i of every port belongs to key i.
- Synchronizer: two flops per key, reset to 1 (released); sync_i is the second flop inverted (1 = pressed).
- Debounce, per clock edge:
  - sync_i == key_state[i]: deb_cnt_i <= 0.
  - sync_i != key_state[i] and deb_cnt_i == DEB_MAX-1: key_state[i] <= sync_i, deb_cnt_i <= 0, pulse key_press[i] (rising) or key_release[i] (falling).
  - otherwise deb_cnt_i <= deb_cnt_i + 1.
- Any return to the accepted level before the count completes clears the counter; glitches shorter than DEB_MAX cycles never reach the outputs.
- Hold counter, per clock edge:
  - key_state[i] == 0: hold_cnt_i <= 0.
  - key_state[i] == 1 and hold_cnt_i == LONG_MAX-1: hold_cnt_i <= LONG_MAX, pulse key_long[i].
  - key_state[i] == 1 and hold_cnt_i == LONG_MAX: hold (saturate); no repeat pulse.
  - otherwise hold_cnt_i <= hold_cnt_i + 1.
- key_long fires at most once per press. A release before LONG_MAX cycles produces key_release only.
- key_release always follows an accepted press, whether or not key_long fired.
- All outputs are registered. key_press, key_release and key_long are never high for two consecutive cycles on the same bit.

## Timing
- Reset values: key_state = 0, key_press = 0, key_release = 0, key_long = 0. Synchronizer flops = 1. All counters = 0.
- Press latency: a level held stable from the first sampling edge E gives key_state/key_press on edge E+DEB_MAX+1, i.e. the (DEB_MAX+2)th sampling edge. The same latency applies to release.
- key_press and key_state rise on the same edge. key_release and the key_state fall share one edge.
- key_long rises exactly LONG_MAX cycles after the edge that raised key_press.
- A key held pressed through reset deassertion is reported as a fresh press DEB_MAX+2 edges after reset release.
- Reset asserted mid-count or mid-hold clears everything immediately. No pulse is emitted on reset entry or exit.
- Simultaneous events on different keys are independent. Multiple bits of a pulse output may be high in the same cycle.

## Test plan
Use simulation parameters DEB_MAX=16 and LONG_MAX=64.
- Reset, key_in=4'hF -> all outputs 0 for 100 cycles; no pulses.
- key_in[0] drops to 0 and holds -> key_state[0] and key_press[0] assert together 18 sampling edges after the drop. key_press is one cycle wide. Other bits stay 0.
- key_in[1] bounces with 0/1 bursts of 5 cycles for 60 cycles, then holds 0 -> exactly one key_press[1], 18 edges after the final stable 0. On later steady release, exactly one key_release[1] after 18 edges.
- key_in[2] held 0 for 200 cycles -> key_press[2], then key_long[2] exactly 64 cycles later, no repeat. On release: key_release[2] only.
- key_in[3] held 0 for 40 cycles -> key_press[3] and key_release[3]; no key_long[3].
- key_in[0] and key_in[3] pressed on the same cycle; sys_rst_n pulsed low mid-hold while key_in[3] stays 0 -> both key_press bits assert on the same edge. Reset clears all outputs at once. key_press[3] reasserts 18 edges after reset release, and key_long[3] 64 cycles after that.
